spi_apb_arbiter: RTL and testbench
==================================

Name: spi_apb_arbiter

Overview:
Two-requester APB arbiter sharing the single SPI/XIP APB slave (flash XIP window plus SPI master registers) between the instruction-fetch port (m0) and the load/store port (m1). It holds the grant for one full downstream APB transfer, re-issues the transfer with clean SETUP/ACCESS phases, and returns a registered response to the winner. A watchdog completes with an error when the downstream slave never answers, such as a stalled SPI transfer.

Parameters:
FIXED_PRIO, 0, 1 = m0 always wins simultaneous requests; 0 = round-robin
TIMEOUT_CYCLES, 1024, ACCESS-phase cycles before forced error completion; 0 disables the watchdog
TO_W, 11, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
m0_paddr / m1_paddr  input  32  requester address
m0_psel / m1_psel  input  1  requester select; this is the request
m0_penable / m1_penable  input  1  requester enable (access phase)
m0_pprot / m1_pprot  input  3  protection, passed through
m0_pwrite / m1_pwrite  input  1  write = 1
m0_pwdata / m1_pwdata  input  32  write data
m0_pstrb / m1_pstrb  input  4  byte strobes
m0_pready / m1_pready  output  1  registered one-cycle completion
m0_prdata / m1_prdata  output  32  registered read data
m0_pslverr / m1_pslverr  output  1  registered error
out_paddr  output  32  downstream address
out_psel  output  1  downstream select
out_penable  output  1  downstream enable
out_pprot  output  3  downstream protection
out_pwrite  output  1  downstream write
out_pwdata  output  32  downstream write data
out_pstrb  output  4  downstream strobes
out_pready  input  1  downstream ready
out_prdata  input  32  downstream read data
out_pslverr  input  1  downstream error
busy  output  1  high whenever the state is not IDLE

Behaviour:
- Reset (async assert, sync release): state = IDLE, last_grant = 1 (so m0 wins first), all out_* = 0, all mN_pready/prdata/pslverr = 0, timeout counter = 0. If reset asserts mid-transfer, out_psel/out_penable drop immediately and the transfer is abandoned.
- The FSM has four states: IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- IDLE: a request is mN_psel = 1 (mN_penable is not required). Only m0 requesting -> grant m0; only m1 requesting -> grant m1. If both request: with FIXED_PRIO = 1, grant m0; otherwise grant the requester that is not last_grant. On a grant, latch that requester's paddr/pprot/pwrite/pwdata/pstrb into the out_* registers, set grant_id and last_grant, then go to SETUP.
- SETUP: out_psel = 1, out_penable = 0; out_pready is ignored; go to ACCESS.
- ACCESS: out_psel = 1, out_penable = 1, and the counter increments each cycle.
  - On out_pready = 1: capture out_prdata/out_pslverr, drop out_psel/out_penable, go to RESP.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES with out_pready still 0: drop out_psel/out_penable, set response prdata = 0 and pslverr = 1, go to RESP.
  - The counter clears on leaving ACCESS.
- RESP: m[grant_id]_pready = 1 for exactly one cycle with the captured prdata/pslverr, but only if m[grant_id]_psel is still 1. A requester that dropped psel gets no response and the data is discarded. Next state is IDLE.
- Non-granted port: pready stays 0 and its prdata/pslverr hold their last values. The requester must hold psel/penable; it is not reordered or cancelled.
- Latency: request sampled in IDLE at cycle N -> out_psel at N+1 -> out_penable at N+2 -> upstream pready at N+3 when out_pready is high on the first ACCESS cycle. The minimum is 3 cycles plus the downstream wait states.
- Back-to-back: the cycle after RESP is IDLE. A requester still holding psel at that point (having ignored its pready) is treated as a new request. A requester that asserts psel in the RESP cycle is granted in the following IDLE cycle, so there is one idle bubble between transfers.
- out_* address/control values are stable from SETUP through ACCESS and only change when a new grant is made.
- Read data is forwarded unmodified; this block performs no byte swapping.

Test Plan:
- Single read: m0_psel at cycle N, paddr = 0x3000_0010, downstream out_pready on first ACCESS cycle with prdata = 0xDEADBEEF -> out_psel at N+1, out_penable at N+2, m0_pready = 1 at N+3 with m0_prdata = 0xDEADBEEF, pslverr = 0, for 1 cycle.
- Simultaneous requests, FIXED_PRIO = 0, from reset, m0 read 0x3000_0000 and m1 write 0x1000_1004 data 0x0300_0000 -> m0 served first, then m1 (out_pwrite = 1, out_pwdata = 0x0300_0000, out_pstrb = 0xF). A third simultaneous round goes to m0 again.
- FIXED_PRIO = 1, both requesting continuously for 3 transfers -> all three grants go to m0; m1 is never granted while m0_psel stays high.
- Downstream wait: out_pready held low 20 cycles, then high with pslverr = 1 -> out_penable high for 21 cycles, m1_pready with m1_pslverr = 1, out_paddr constant throughout.
- Timeout, TIMEOUT_CYCLES = 8, out_pready never asserted -> out_psel drops after 8 ACCESS cycles, requester gets pready = 1, pslverr = 1, prdata = 0x0, and busy returns to 0 the next cycle.
- Reset mid-ACCESS -> out_psel/out_penable = 0 the same cycle as reset assertion. After release, a fresh m1 request completes normally with m0 still winning a simultaneous tie.

Source files
------------

// File: rtl/spi_apb_arbiter_if.sv
// Bus bundle for the SPI/XIP APB arbiter: two upstream requester ports and one downstream slave port.
// The slave modport is the arbiter's view; the master modport is the view of whatever drives it.
interface spi_apb_arbiter_if;
    logic [31:0] m0_paddr;
    logic        m0_psel;
    logic        m0_penable;
    logic [2:0]  m0_pprot;
    logic        m0_pwrite;
    logic [31:0] m0_pwdata;
    logic [3:0]  m0_pstrb;
    logic        m0_pready;
    logic [31:0] m0_prdata;
    logic        m0_pslverr;

    logic [31:0] m1_paddr;
    logic        m1_psel;
    logic        m1_penable;
    logic [2:0]  m1_pprot;
    logic        m1_pwrite;
    logic [31:0] m1_pwdata;
    logic [3:0]  m1_pstrb;
    logic        m1_pready;
    logic [31:0] m1_prdata;
    logic        m1_pslverr;

    logic [31:0] out_paddr;
    logic        out_psel;
    logic        out_penable;
    logic [2:0]  out_pprot;
    logic        out_pwrite;
    logic [31:0] out_pwdata;
    logic [3:0]  out_pstrb;
    logic        out_pready;
    logic [31:0] out_prdata;
    logic        out_pslverr;

    modport slave (
        input  m0_paddr, m0_psel, m0_penable, m0_pprot, m0_pwrite, m0_pwdata, m0_pstrb,
        output m0_pready, m0_prdata, m0_pslverr,
        input  m1_paddr, m1_psel, m1_penable, m1_pprot, m1_pwrite, m1_pwdata, m1_pstrb,
        output m1_pready, m1_prdata, m1_pslverr,
        output out_paddr, out_psel, out_penable, out_pprot, out_pwrite, out_pwdata, out_pstrb,
        input  out_pready, out_prdata, out_pslverr
    );

    modport master (
        output m0_paddr, m0_psel, m0_penable, m0_pprot, m0_pwrite, m0_pwdata, m0_pstrb,
        input  m0_pready, m0_prdata, m0_pslverr,
        output m1_paddr, m1_psel, m1_penable, m1_pprot, m1_pwrite, m1_pwdata, m1_pstrb,
        input  m1_pready, m1_prdata, m1_pslverr,
        input  out_paddr, out_psel, out_penable, out_pprot, out_pwrite, out_pwdata, out_pstrb,
        output out_pready, out_prdata, out_pslverr
    );
endinterface

// File: rtl/spi_apb_arbiter.sv
// Two-requester APB arbiter in front of the SPI/XIP slave: grants one full downstream transfer,
// re-issues it with clean SETUP/ACCESS phases and returns a registered response, with a watchdog.
module spi_apb_arbiter #(
    parameter int FIXED_PRIO     = 0,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = 11
) (
    input  logic              clock,
    input  logic              reset,
    spi_apb_arbiter_if.slave  bus,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam int              TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TO_LAST_I);

    state_t          r_state;
    state_t          w_next;
    logic            w_grant_valid;
    logic            w_gid;
    logic            w_timeout;
    logic [31:0]     w_rsp_data;
    logic            w_rsp_err;
    logic            w_unused;

    logic            r_grant_id;
    logic            r_last_grant;
    logic [TO_W-1:0] r_cnt;

    logic [31:0]     r_out_paddr;
    logic            r_out_psel;
    logic            r_out_penable;
    logic [2:0]      r_out_pprot;
    logic            r_out_pwrite;
    logic [31:0]     r_out_pwdata;
    logic [3:0]      r_out_pstrb;

    logic            r_m0_pready;
    logic [31:0]     r_m0_prdata;
    logic            r_m0_pslverr;
    logic            r_m1_pready;
    logic [31:0]     r_m1_prdata;
    logic            r_m1_pslverr;

    // Requesters only need psel to be considered; penable is accepted but not used.
    assign w_unused = bus.m0_penable ^ bus.m1_penable;

    always_comb begin
        w_grant_valid = bus.m0_psel | bus.m1_psel;
        w_gid         = ~bus.m0_psel;
        if (bus.m0_psel && bus.m1_psel) begin
            w_gid = (FIXED_PRIO != 0) ? 1'b0 : ~r_last_grant;
        end
        w_timeout  = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST) && !bus.out_pready;
        w_rsp_data = bus.out_pready ? bus.out_prdata : 32'h0;
        w_rsp_err  = bus.out_pready ? bus.out_pslverr : 1'b1;
        w_next     = r_state;
        case (r_state)
            IDLE:    if (w_grant_valid) w_next = SETUP;
            SETUP:   w_next = ACCESS;
            ACCESS:  if (bus.out_pready || w_timeout) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Downstream phase signals follow the next state so they line up with the registered FSM.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_grant_id    <= 1'b0;
            r_last_grant  <= 1'b1;
            r_cnt         <= '0;
            r_out_paddr   <= 32'h0;
            r_out_psel    <= 1'b0;
            r_out_penable <= 1'b0;
            r_out_pprot   <= 3'h0;
            r_out_pwrite  <= 1'b0;
            r_out_pwdata  <= 32'h0;
            r_out_pstrb   <= 4'h0;
            r_m0_pready   <= 1'b0;
            r_m0_prdata   <= 32'h0;
            r_m0_pslverr  <= 1'b0;
            r_m1_pready   <= 1'b0;
            r_m1_prdata   <= 32'h0;
            r_m1_pslverr  <= 1'b0;
        end else begin
            r_out_psel    <= (w_next == SETUP) || (w_next == ACCESS);
            r_out_penable <= (w_next == ACCESS);
            r_cnt         <= ((r_state == ACCESS) && (w_next == ACCESS)) ? r_cnt + 1'b1 : '0;
            r_m0_pready   <= 1'b0;
            r_m1_pready   <= 1'b0;

            if ((r_state == IDLE) && w_grant_valid) begin
                r_grant_id   <= w_gid;
                r_last_grant <= w_gid;
                r_out_paddr  <= w_gid ? bus.m1_paddr  : bus.m0_paddr;
                r_out_pprot  <= w_gid ? bus.m1_pprot  : bus.m0_pprot;
                r_out_pwrite <= w_gid ? bus.m1_pwrite : bus.m0_pwrite;
                r_out_pwdata <= w_gid ? bus.m1_pwdata : bus.m0_pwdata;
                r_out_pstrb  <= w_gid ? bus.m1_pstrb  : bus.m0_pstrb;
            end

            // A requester that has already let go of psel gets nothing back.
            if ((r_state == ACCESS) && (w_next == RESP)) begin
                if (!r_grant_id && bus.m0_psel) begin
                    r_m0_pready  <= 1'b1;
                    r_m0_prdata  <= w_rsp_data;
                    r_m0_pslverr <= w_rsp_err;
                end
                if (r_grant_id && bus.m1_psel) begin
                    r_m1_pready  <= 1'b1;
                    r_m1_prdata  <= w_rsp_data;
                    r_m1_pslverr <= w_rsp_err;
                end
            end
        end
    end

    assign bus.out_paddr   = r_out_paddr;
    assign bus.out_psel    = r_out_psel;
    assign bus.out_penable = r_out_penable;
    assign bus.out_pprot   = r_out_pprot;
    assign bus.out_pwrite  = r_out_pwrite;
    assign bus.out_pwdata  = r_out_pwdata;
    assign bus.out_pstrb   = r_out_pstrb;
    assign bus.m0_pready   = r_m0_pready;
    assign bus.m0_prdata   = r_m0_prdata;
    assign bus.m0_pslverr  = r_m0_pslverr;
    assign bus.m1_pready   = r_m1_pready;
    assign bus.m1_prdata   = r_m1_prdata;
    assign bus.m1_pslverr  = r_m1_pslverr;
    assign busy            = (r_state != IDLE);

endmodule

// File: tb/tb_spi_apb_arbiter.sv
// Directed bench for spi_apb_arbiter: a round-robin instance with a long watchdog (A) and a
// fixed-priority instance with an 8-cycle watchdog (B), sharing clock and reset.
module tb_spi_apb_arbiter;

    logic clock;
    logic reset;
    logic busyA;
    logic busyB;
    int   total;
    int   bad;

    spi_apb_arbiter_if ifA();
    spi_apb_arbiter_if ifB();

    spi_apb_arbiter #(.FIXED_PRIO(0), .TIMEOUT_CYCLES(32), .TO_W(6)) dutA (
        .clock (clock),
        .reset (reset),
        .bus   (ifA),
        .busy  (busyA)
    );

    spi_apb_arbiter #(.FIXED_PRIO(1), .TIMEOUT_CYCLES(8), .TO_W(4)) dutB (
        .clock (clock),
        .reset (reset),
        .bus   (ifB),
        .busy  (busyB)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic init_inputs;
        ifA.m0_paddr = '0; ifA.m0_psel = 0; ifA.m0_penable = 0; ifA.m0_pprot = '0;
        ifA.m0_pwrite = 0; ifA.m0_pwdata = '0; ifA.m0_pstrb = '0;
        ifA.m1_paddr = '0; ifA.m1_psel = 0; ifA.m1_penable = 0; ifA.m1_pprot = '0;
        ifA.m1_pwrite = 0; ifA.m1_pwdata = '0; ifA.m1_pstrb = '0;
        ifA.out_pready = 0; ifA.out_prdata = '0; ifA.out_pslverr = 0;
        ifB.m0_paddr = '0; ifB.m0_psel = 0; ifB.m0_penable = 0; ifB.m0_pprot = '0;
        ifB.m0_pwrite = 0; ifB.m0_pwdata = '0; ifB.m0_pstrb = '0;
        ifB.m1_paddr = '0; ifB.m1_psel = 0; ifB.m1_penable = 0; ifB.m1_pprot = '0;
        ifB.m1_pwrite = 0; ifB.m1_pwdata = '0; ifB.m1_pstrb = '0;
        ifB.out_pready = 0; ifB.out_prdata = '0; ifB.out_pslverr = 0;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        tick;
        tick;
        reset = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        init_inputs;
        tick;
        tick;
        total++; if (ifA.out_psel !== 1'b0) begin bad++; $display("[TB] FAIL rst_psel got=%b exp=0", ifA.out_psel); end
        total++; if (ifA.out_paddr !== 32'h0) begin bad++; $display("[TB] FAIL rst_paddr got=%h exp=0", ifA.out_paddr); end
        total++; if (ifA.m0_pready !== 1'b0) begin bad++; $display("[TB] FAIL rst_m0_pready got=%b exp=0", ifA.m0_pready); end
        total++; if (ifA.m1_prdata !== 32'h0) begin bad++; $display("[TB] FAIL rst_m1_prdata got=%h exp=0", ifA.m1_prdata); end
        total++; if (busyA !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy got=%b exp=0", busyA); end
        total++; if (ifB.out_penable !== 1'b0) begin bad++; $display("[TB] FAIL rst_b_penable got=%b exp=0", ifB.out_penable); end
        reset = 1'b1;
    endtask

    task automatic test_single_read;
        ifA.m0_psel = 1; ifA.m0_paddr = 32'h3000_0010; ifA.m0_pwrite = 0; ifA.m0_pprot = 3'h2;
        ifA.out_pready = 1; ifA.out_prdata = 32'hDEAD_BEEF; ifA.out_pslverr = 0;
        tick;
        ifA.m0_penable = 1;
        total++; if (ifA.out_psel !== 1'b1 || ifA.out_penable !== 1'b0) begin bad++; $display("[TB] FAIL sr_setup got=%b%b exp=10", ifA.out_psel, ifA.out_penable); end
        total++; if (ifA.out_paddr !== 32'h3000_0010) begin bad++; $display("[TB] FAIL sr_paddr got=%h exp=30000010", ifA.out_paddr); end
        total++; if (ifA.out_pprot !== 3'h2) begin bad++; $display("[TB] FAIL sr_pprot got=%h exp=2", ifA.out_pprot); end
        tick;
        total++; if (ifA.out_penable !== 1'b1 || ifA.m0_pready !== 1'b0) begin bad++; $display("[TB] FAIL sr_access got=%b%b exp=10", ifA.out_penable, ifA.m0_pready); end
        tick;
        total++; if (ifA.m0_pready !== 1'b1) begin bad++; $display("[TB] FAIL sr_pready got=%b exp=1", ifA.m0_pready); end
        total++; if (ifA.m0_prdata !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL sr_prdata got=%h exp=deadbeef", ifA.m0_prdata); end
        total++; if (ifA.m0_pslverr !== 1'b0) begin bad++; $display("[TB] FAIL sr_pslverr got=%b exp=0", ifA.m0_pslverr); end
        total++; if (ifA.out_psel !== 1'b0) begin bad++; $display("[TB] FAIL sr_psel_drop got=%b exp=0", ifA.out_psel); end
        ifA.m0_psel = 0; ifA.m0_penable = 0; ifA.out_pready = 0;
        tick;
        total++; if (ifA.m0_pready !== 1'b0 || busyA !== 1'b0) begin bad++; $display("[TB] FAIL sr_end got=%b%b exp=00", ifA.m0_pready, busyA); end
    endtask

    task automatic test_round_robin;
        do_reset;
        ifA.m0_psel = 1; ifA.m0_penable = 1; ifA.m0_paddr = 32'h3000_0000; ifA.m0_pwrite = 0; ifA.m0_pstrb = 4'h0;
        ifA.m1_psel = 1; ifA.m1_penable = 1; ifA.m1_paddr = 32'h1000_1004; ifA.m1_pwrite = 1;
        ifA.m1_pwdata = 32'h0300_0000; ifA.m1_pstrb = 4'hF;
        ifA.out_pready = 1; ifA.out_prdata = 32'hAAAA_0001; ifA.out_pslverr = 0;
        tick;
        total++; if (ifA.out_paddr !== 32'h3000_0000 || ifA.out_pwrite !== 1'b0) begin bad++; $display("[TB] FAIL rr1_grant got=%h/%b exp=30000000/0", ifA.out_paddr, ifA.out_pwrite); end
        tick;
        tick;
        total++; if (ifA.m0_pready !== 1'b1 || ifA.m1_pready !== 1'b0) begin bad++; $display("[TB] FAIL rr1_resp got=%b%b exp=10", ifA.m0_pready, ifA.m1_pready); end
        total++; if (ifA.m0_prdata !== 32'hAAAA_0001) begin bad++; $display("[TB] FAIL rr1_prdata got=%h exp=aaaa0001", ifA.m0_prdata); end
        ifA.out_prdata = 32'hBBBB_0002;
        tick;
        total++; if (busyA !== 1'b0) begin bad++; $display("[TB] FAIL rr_bubble got=%b exp=0", busyA); end
        tick;
        total++; if (ifA.out_paddr !== 32'h1000_1004 || ifA.out_pwrite !== 1'b1) begin bad++; $display("[TB] FAIL rr2_grant got=%h/%b exp=10001004/1", ifA.out_paddr, ifA.out_pwrite); end
        total++; if (ifA.out_pwdata !== 32'h0300_0000 || ifA.out_pstrb !== 4'hF) begin bad++; $display("[TB] FAIL rr2_wdata got=%h/%h exp=03000000/f", ifA.out_pwdata, ifA.out_pstrb); end
        tick;
        tick;
        total++; if (ifA.m1_pready !== 1'b1 || ifA.m0_pready !== 1'b0) begin bad++; $display("[TB] FAIL rr2_resp got=%b%b exp=10", ifA.m1_pready, ifA.m0_pready); end
        total++; if (ifA.m1_prdata !== 32'hBBBB_0002) begin bad++; $display("[TB] FAIL rr2_prdata got=%h exp=bbbb0002", ifA.m1_prdata); end
        total++; if (ifA.m0_prdata !== 32'hAAAA_0001) begin bad++; $display("[TB] FAIL rr2_m0_hold got=%h exp=aaaa0001", ifA.m0_prdata); end
        tick;
        tick;
        total++; if (ifA.out_paddr !== 32'h3000_0000) begin bad++; $display("[TB] FAIL rr3_grant got=%h exp=30000000", ifA.out_paddr); end
        tick;
        tick;
        total++; if (ifA.m0_pready !== 1'b1) begin bad++; $display("[TB] FAIL rr3_resp got=%b exp=1", ifA.m0_pready); end
        ifA.m0_psel = 0; ifA.m0_penable = 0; ifA.m1_psel = 0; ifA.m1_penable = 0; ifA.out_pready = 0;
        tick;
        tick;
    endtask

    task automatic test_wait_state;
        int enCount;
        int addrBad;
        enCount = 0;
        addrBad = 0;
        ifA.m1_psel = 1; ifA.m1_penable = 1; ifA.m1_paddr = 32'h1000_0008; ifA.m1_pwrite = 1;
        ifA.m1_pwdata = 32'h0000_00A5; ifA.m1_pstrb = 4'h1;
        ifA.out_pready = 0; ifA.out_pslverr = 0; ifA.out_prdata = 32'h0;
        tick;
        for (int i = 0; i < 21; i++) begin
            tick;
            if (ifA.out_penable === 1'b1) enCount++;
            if (ifA.out_paddr !== 32'h1000_0008) addrBad++;
        end
        ifA.out_pready = 1; ifA.out_pslverr = 1;
        tick;
        total++; if (enCount !== 21) begin bad++; $display("[TB] FAIL ws_penable_cycles got=%0d exp=21", enCount); end
        total++; if (addrBad !== 0) begin bad++; $display("[TB] FAIL ws_paddr_stable got=%0d exp=0", addrBad); end
        total++; if (ifA.m1_pready !== 1'b1 || ifA.m1_pslverr !== 1'b1) begin bad++; $display("[TB] FAIL ws_resp got=%b%b exp=11", ifA.m1_pready, ifA.m1_pslverr); end
        total++; if (ifA.out_penable !== 1'b0) begin bad++; $display("[TB] FAIL ws_penable_drop got=%b exp=0", ifA.out_penable); end
        ifA.m1_psel = 0; ifA.m1_penable = 0; ifA.out_pready = 0; ifA.out_pslverr = 0;
        tick;
    endtask

    task automatic test_drop_psel;
        logic [31:0] prevData;
        prevData = ifA.m0_prdata;
        ifA.m0_psel = 1; ifA.m0_penable = 1; ifA.m0_paddr = 32'h3000_0020; ifA.m0_pwrite = 0;
        ifA.out_pready = 0; ifA.out_prdata = 32'h7777_7777;
        tick;
        tick;
        ifA.m0_psel = 0; ifA.m0_penable = 0; ifA.out_pready = 1;
        tick;
        total++; if (ifA.m0_pready !== 1'b0) begin bad++; $display("[TB] FAIL dp_pready got=%b exp=0", ifA.m0_pready); end
        total++; if (ifA.m0_prdata !== prevData) begin bad++; $display("[TB] FAIL dp_prdata got=%h exp=%h", ifA.m0_prdata, prevData); end
        ifA.out_pready = 0;
        tick;
    endtask

    task automatic test_reset_mid;
        ifA.m0_psel = 1; ifA.m0_penable = 1; ifA.m0_paddr = 32'h3000_0030; ifA.m0_pwrite = 0;
        ifA.out_pready = 0;
        tick;
        tick;
        tick;
        total++; if (ifA.out_penable !== 1'b1) begin bad++; $display("[TB] FAIL rm_in_access got=%b exp=1", ifA.out_penable); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (ifA.out_psel !== 1'b0 || ifA.out_penable !== 1'b0) begin bad++; $display("[TB] FAIL rm_async_drop got=%b%b exp=00", ifA.out_psel, ifA.out_penable); end
        total++; if (busyA !== 1'b0) begin bad++; $display("[TB] FAIL rm_busy got=%b exp=0", busyA); end
        tick;
        tick;
        reset = 1'b1;
        ifA.m1_psel = 1; ifA.m1_penable = 1; ifA.m1_paddr = 32'h1000_0040; ifA.m1_pwrite = 0;
        ifA.out_pready = 1; ifA.out_prdata = 32'h1234_5678; ifA.out_pslverr = 0;
        tick;
        total++; if (ifA.out_paddr !== 32'h3000_0030) begin bad++; $display("[TB] FAIL rm_tie_m0 got=%h exp=30000030", ifA.out_paddr); end
        tick;
        tick;
        total++; if (ifA.m0_pready !== 1'b1) begin bad++; $display("[TB] FAIL rm_m0_resp got=%b exp=1", ifA.m0_pready); end
        ifA.m0_psel = 0; ifA.m0_penable = 0;
        tick;
        tick;
        total++; if (ifA.out_paddr !== 32'h1000_0040) begin bad++; $display("[TB] FAIL rm_m1_grant got=%h exp=10000040", ifA.out_paddr); end
        tick;
        tick;
        total++; if (ifA.m1_pready !== 1'b1 || ifA.m1_prdata !== 32'h1234_5678) begin bad++; $display("[TB] FAIL rm_m1_resp got=%b/%h exp=1/12345678", ifA.m1_pready, ifA.m1_prdata); end
        ifA.m1_psel = 0; ifA.m1_penable = 0; ifA.out_pready = 0;
        tick;
    endtask

    task automatic test_fixed_prio;
        ifB.m0_psel = 1; ifB.m0_penable = 1; ifB.m0_paddr = 32'h3000_0100; ifB.m0_pwrite = 0;
        ifB.m1_psel = 1; ifB.m1_penable = 1; ifB.m1_paddr = 32'h1000_2000; ifB.m1_pwrite = 1;
        ifB.out_pready = 1; ifB.out_prdata = 32'hC0DE_0000;
        for (int i = 0; i < 3; i++) begin
            tick;
            total++; if (ifB.out_paddr !== 32'h3000_0100) begin bad++; $display("[TB] FAIL fp_grant%0d got=%h exp=30000100", i, ifB.out_paddr); end
            tick;
            tick;
            total++; if (ifB.m0_pready !== 1'b1 || ifB.m1_pready !== 1'b0) begin bad++; $display("[TB] FAIL fp_resp%0d got=%b%b exp=10", i, ifB.m0_pready, ifB.m1_pready); end
            tick;
        end
        ifB.m0_psel = 0; ifB.m0_penable = 0;
        tick;
        total++; if (ifB.out_paddr !== 32'h1000_2000) begin bad++; $display("[TB] FAIL fp_m1_grant got=%h exp=10002000", ifB.out_paddr); end
        tick;
        tick;
        total++; if (ifB.m1_pready !== 1'b1) begin bad++; $display("[TB] FAIL fp_m1_resp got=%b exp=1", ifB.m1_pready); end
        ifB.m1_psel = 0; ifB.m1_penable = 0; ifB.out_pready = 0;
        tick;
    endtask

    task automatic test_timeout;
        int  accessCycles;
        bit  done;
        accessCycles = 0;
        done = 0;
        ifB.m0_psel = 1; ifB.m0_penable = 1; ifB.m0_paddr = 32'h3000_0040; ifB.m0_pwrite = 0;
        ifB.out_pready = 0; ifB.out_prdata = 32'h5555_5555; ifB.out_pslverr = 0;
        tick;
        for (int i = 0; i < 40 && !done; i++) begin
            tick;
            if (ifB.out_psel === 1'b0) done = 1;
            else if (ifB.out_penable === 1'b1) accessCycles++;
        end
        total++; if (!done) begin bad++; $display("[TB] FAIL to_expired got=%b exp=1", done); end
        total++; if (accessCycles !== 8) begin bad++; $display("[TB] FAIL to_cycles got=%0d exp=8", accessCycles); end
        total++; if (ifB.m0_pready !== 1'b1 || ifB.m0_pslverr !== 1'b1) begin bad++; $display("[TB] FAIL to_resp got=%b%b exp=11", ifB.m0_pready, ifB.m0_pslverr); end
        total++; if (ifB.m0_prdata !== 32'h0) begin bad++; $display("[TB] FAIL to_prdata got=%h exp=0", ifB.m0_prdata); end
        ifB.m0_psel = 0; ifB.m0_penable = 0;
        tick;
        total++; if (busyB !== 1'b0 || ifB.m0_pready !== 1'b0) begin bad++; $display("[TB] FAIL to_idle got=%b%b exp=00", busyB, ifB.m0_pready); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset;
        test_single_read;
        test_round_robin;
        test_wait_state;
        test_drop_psel;
        test_reset_mid;
        test_fixed_prio;
        test_timeout;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
